// File: rtl/mmio_timer_resp_pkg.sv
// Shared constants for the MMIO timer/display responder: register offsets,
// CTRL/STATUS bit positions and the default register window base.
package mmio_timer_resp_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Word offsets within the window (addr[5:2]).
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h1;
  localparam logic [3:0] OFF_COUNT  = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;
  localparam logic [3:0] OFF_SEG    = 4'h4;
  localparam logic [3:0] OFF_PRESC  = 4'h5;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_RELOAD    = 1;
  localparam int unsigned CTRL_IRQEN     = 2;
  localparam int unsigned STATUS_EXPIRED = 0;

endpackage

// File: rtl/mmio_prescaler.sv
// Timer prescaler: counts enabled cycles and emits a one-cycle tick each time
// the count matches the programmed divisor, then wraps to zero.
module mmio_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == presc);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (!en || restart || tick) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer_resp.sv
// Data-bus responder hosting a prescaled down-counting timer, a 7-segment
// display register and a level interrupt. Reads are combinational.
module mmio_timer_resp
  import mmio_timer_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rena,
  input  logic        wena,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq,
  output logic [31:0] seg_value
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               expired_q, expired_d;
  logic [31:0]        seg_q, seg_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               irq_q;

  logic [3:0] off;
  logic       wr;
  logic       tick;
  logic       restart;
  logic       unused_addr_bits;

  assign hit              = (addr[31:6] == BASE_ADDR[31:6]);
  assign off              = addr[5:2];
  assign wr               = hit && wena;
  assign unused_addr_bits = ^addr[1:0];

  // Counter restarts on a divisor change or when the timer is switched on.
  assign restart = wr && ((off == OFF_PRESC) ||
                          ((off == OFF_CTRL) && wdata[CTRL_EN] && !ctrl_q[CTRL_EN]));

  mmio_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q[CTRL_EN]),
    .presc  (presc_q),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    seg_d     = seg_q;
    presc_d   = presc_q;

    // W1C first so a same-cycle hardware set wins.
    if (wr && (off == OFF_STATUS) && wdata[STATUS_EXPIRED]) begin
      expired_d = 1'b0;
    end

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[CTRL_RELOAD]) begin
          count_d = load_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end
    end

    // CPU writes override the timer's own updates.
    if (wr) begin
      case (off)
        OFF_CTRL:  ctrl_d  = wdata[2:0];
        OFF_LOAD:  load_d  = wdata;
        OFF_COUNT: count_d = wdata;
        OFF_SEG:   seg_d   = wdata;
        OFF_PRESC: presc_d = wdata[PRESC_W-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      seg_q     <= '0;
      presc_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      seg_q     <= seg_d;
      presc_q   <= presc_d;
      irq_q     <= expired_q && ctrl_q[CTRL_IRQEN];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && rena) begin
      case (off)
        OFF_CTRL:   rdata = {29'd0, ctrl_q};
        OFF_LOAD:   rdata = load_q;
        OFF_COUNT:  rdata = count_q;
        OFF_STATUS: rdata = {31'd0, expired_q};
        OFF_SEG:    rdata = seg_q;
        OFF_PRESC:  rdata = 32'(presc_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign irq       = irq_q;
  assign seg_value = seg_q;

endmodule

// File: tb/tb_mmio_timer_resp.sv
// Directed self-checking bench for mmio_timer_resp: decode, one-shot,
// auto-reload with prescale, write/tick collisions, SEG and mid-run reset.
module tb_mmio_timer_resp;

  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_LOAD = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_SEG  = BASE + 32'h10;
  localparam logic [31:0] A_PRSC = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata, seg_value;
  logic        rena, wena, hit, irq;

  int n_cmp = 0;
  int n_err = 0;

  mmio_timer_resp dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .rena     (rena),
    .wena     (wena),
    .rdata    (rdata),
    .hit      (hit),
    .irq      (irq),
    .seg_value(seg_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wena  = 1'b1;
    step();
    wena  = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    rena = 1'b1;
    #1;
    d    = rdata;
    h    = hit;
    rena = 1'b0;
  endtask

  logic [31:0] rv;
  logic        hv;
  logic [31:0] exp_seq [6] = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    rena  = 1'b0;
    wena  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values and decode
    for (int i = 0; i < 6; i++) begin
      bus_rd(BASE + 32'(i * 4), rv, hv);
      check($sformatf("reset_reg%0d", i), rv, 32'd0);
      step();
    end
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_seg", seg_value, 32'd0);
    bus_rd(32'h1001_0040, rv, hv);
    check("miss_hit", {31'd0, hv}, 32'd0);
    check("miss_rdata", rv, 32'd0);
    bus_rd(32'h1001_0018, rv, hv);
    check("unmapped_hit", {31'd0, hv}, 32'd1);
    check("unmapped_rdata", rv, 32'd0);

    // One-shot, no prescale
    bus_wr(A_PRSC, 32'd0);
    bus_wr(A_CNT, 32'd3);
    bus_wr(A_CTRL, 32'h5);
    bus_rd(A_CNT, rv, hv);
    check("os_cnt3", rv, 32'd3);
    for (int i = 2; i >= 0; i--) begin
      step();
      bus_rd(A_CNT, rv, hv);
      check($sformatf("os_cnt%0d", i), rv, 32'(i));
    end
    step();
    bus_rd(A_STAT, rv, hv);
    check("os_expired", rv, 32'd1);
    bus_rd(A_CTRL, rv, hv);
    check("os_en_cleared", rv, 32'h4);
    check("os_irq_not_yet", {31'd0, irq}, 32'd0);
    step();
    check("os_irq", {31'd0, irq}, 32'd1);
    repeat (3) step();
    bus_rd(A_CNT, rv, hv);
    check("os_cnt_hold", rv, 32'd0);
    bus_wr(A_STAT, 32'd1);
    bus_rd(A_STAT, rv, hv);
    check("os_w1c", rv, 32'd0);
    check("os_irq_lag", {31'd0, irq}, 32'd1);
    step();
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    bus_wr(A_CTRL, 32'h0);

    // Auto-reload with prescale 3 (tick every 4 cycles)
    bus_wr(A_LOAD, 32'd2);
    bus_wr(A_CNT, 32'd2);
    bus_wr(A_PRSC, 32'd3);
    bus_wr(A_CTRL, 32'h3);
    for (int k = 0; k < 24; k++) begin
      bus_rd(A_CNT, rv, hv);
      check($sformatf("ar_cnt_k%0d", k), rv, exp_seq[k/4]);
      if (k == 11 || k == 12) begin
        bus_rd(A_STAT, rv, hv);
        check($sformatf("ar_expired_k%0d", k), rv, (k == 12) ? 32'd1 : 32'd0);
      end
      step();
    end
    bus_rd(A_PRSC, rv, hv);
    check("ar_presc_rb", rv, 32'd3);
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STAT, 32'd1);

    // Collisions
    bus_wr(A_PRSC, 32'd0);
    bus_wr(A_CNT, 32'd10);
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_CNT, 32'd100);
    bus_rd(A_CNT, rv, hv);
    check("col_cnt_write_wins", rv, 32'd100);
    bus_wr(A_CNT, 32'd0);
    bus_wr(A_STAT, 32'd1);
    bus_rd(A_STAT, rv, hv);
    check("col_set_beats_w1c", rv, 32'd1);
    bus_rd(A_CTRL, rv, hv);
    check("col_oneshot_off", rv, 32'd0);
    bus_wr(A_STAT, 32'd1);
    bus_rd(A_STAT, rv, hv);
    check("col_w1c_after", rv, 32'd0);

    // SEG passthrough and read/write collision
    bus_wr(A_SEG, 32'hDEAD_BEEF);
    check("seg_out", seg_value, 32'hDEAD_BEEF);
    bus_rd(A_SEG, rv, hv);
    check("seg_rb", rv, 32'hDEAD_BEEF);
    addr  = A_SEG;
    wdata = 32'h0000_0001;
    rena  = 1'b1;
    wena  = 1'b1;
    #1;
    check("rw_old", rdata, 32'hDEAD_BEEF);
    step();
    wena = 1'b0;
    check("rw_new", rdata, 32'h0000_0001);
    rena = 1'b0;
    bus_wr(32'h1000_0010, 32'h1234_5678);
    check("seg_nohit", seg_value, 32'h0000_0001);

    // Reset mid-operation
    bus_wr(A_LOAD, 32'd5);
    bus_wr(A_CNT, 32'd5);
    bus_wr(A_CTRL, 32'h7);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_rd(A_CNT, rv, hv);
    check("rst_cnt", rv, 32'd0);
    bus_rd(A_CTRL, rv, hv);
    check("rst_ctrl", rv, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_seg", seg_value, 32'd0);
    repeat (5) step();
    bus_rd(A_CNT, rv, hv);
    check("rst_cnt_idle", rv, 32'd0);
    bus_rd(A_STAT, rv, hv);
    check("rst_stat_idle", rv, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_timer_resp.md
Name: mmio_timer_resp

Overview:
- Responder on the CPU data-memory bus (addr/wdata/rena/wena/rdata), decoded beside the RAM; hosts a programmable down-counting timer, a 7-segment display register and an interrupt flag.
- The CPU is single-cycle, so reads are combinational (same cycle) and writes commit on the next posedge clk.
- The top level muxes rdata between RAM and this block using the hit output.

Parameters:
- BASE_ADDR, 32'h1001_0000, base of the 64-byte register window (must be 64-byte aligned).
- PRESC_W, 16, width of the prescaler register and its counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from CPU.
- wdata  in  32  CPU write data.
- rena  in  1  read strobe.
- wena  in  1  write strobe.
- rdata  out  32  read data, combinational.
- hit  out  1  addr[31:6]==BASE_ADDR[31:6], combinational.
- irq  out  1  STATUS.expired & CTRL.irq_en, registered.
- seg_value  out  32  SEG register, drives display driver.

Behaviour:
- Register map (offset = addr[5:2]):
  - 0x00 CTRL: bit0 en, bit1 reload, bit2 irq_en; other bits read 0.
  - 0x04 LOAD: 32-bit.
  - 0x08 COUNT: read current count; write sets count.
  - 0x0C STATUS: bit0 expired; write 1 to clear.
  - 0x10 SEG: 32-bit.
  - 0x14 PRESC: PRESC_W bits, zero-extended on read.
- Unmapped offsets read 0 and ignore writes. addr[1:0] is ignored; there are no byte lanes.
- Read: rdata = selected register when hit & rena, else 32'h0. No side effects on read.
- Write: takes effect at the posedge where hit & wena. Write without hit is ignored.
- Reset (sync): CTRL=0, LOAD=0, COUNT=0, STATUS=0, SEG=0, PRESC=0, prescale counter=0, irq=0.
- Prescaler:
  - When en=1, pcnt increments each cycle.
  - When pcnt==PRESC, a tick is generated and pcnt<=0.
  - PRESC=0 gives a tick every cycle.
  - en=0 holds pcnt at 0.
- Tick processing:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: expired<=1. If reload=1, COUNT<=LOAD; if reload=0, COUNT stays 0 and en<=0 (one-shot).
- Priorities within one cycle:
  - CPU write to COUNT beats decrement/reload.
  - CPU write to CTRL beats the one-shot auto-clear of en.
  - Hardware set of expired beats a W1C clear in the same cycle.
- Writing PRESC resets pcnt to 0.
- Writing CTRL with en 0->1 restarts pcnt at 0.
- irq = registered (expired & irq_en), so it is 1 cycle after the condition. It deasserts 1 cycle after clear.
- LOAD=0 with reload=1: expired sets on every tick.
- Reset mid-count: all state returns to reset values next edge. No pending tick survives.
- Simultaneous rena and wena to the same register: rdata shows the old value, and the new value is visible from the next cycle.

Decomposition:
- Shared package holds:
  - Register offset constants (OFF_CTRL..OFF_PRESC).
  - CTRL bit indices (CTRL_EN, CTRL_RELOAD, CTRL_IRQEN).
  - STATUS_EXPIRED index.
  - Default BASE_ADDR.
- One natural sub-module: mmio_prescaler.
  - Inputs: clk, reset, en, presc, restart.
  - Output: tick.
- Decode, register file and counter logic stay in mmio_timer_resp.

Test Plan:
- Reset/decode:
  - Assert reset 2 cycles, then read all six offsets -> all return 0.
  - Read addr 0x1001_0040 -> hit=0, rdata=0.
  - Read 0x1001_0018 -> hit=1, rdata=0.
- One-shot:
  - Write PRESC=0, COUNT=3, CTRL=0x5.
  - COUNT reads 2,1,0 on successive cycles.
  - Next cycle: expired=1 and CTRL.en=0.
  - One cycle later: irq=1.
  - COUNT stays 0 thereafter.
- Auto-reload with prescale:
  - Write LOAD=2, COUNT=2, PRESC=3, CTRL=0x3.
  - COUNT changes every 4 cycles: 2,1,0,2,1,0.
  - expired set at the first 0->reload tick.
- Collisions:
  - Write COUNT=100 on the same edge as a tick -> COUNT reads 100, not decremented.
  - W1C to STATUS on the same edge expired sets -> expired remains 1.
- SEG passthrough:
  - Write SEG=0xDEAD_BEEF -> seg_value=0xDEAD_BEEF next cycle, readback matches.
  - Write to 0x1000_0010 (no hit) -> seg_value unchanged.
- Reset mid-operation:
  - Auto-reload running with COUNT=5; assert reset 1 cycle.
  - Next cycle: COUNT=0, CTRL=0, irq=0.
  - No further ticks.
